// File: rtl/taxi_axil_register_rd_if.sv
// taxi_axil_if: AXI4-lite interface, read channels only, with rd_mst/rd_slv modports.
// Widths and user-field enables are parameters so that connected blocks can cross-check them.
interface taxi_axil_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned STRB_W    = DATA_W / 8,
  parameter bit          ARUSER_EN = 1'b0,
  parameter int unsigned ARUSER_W  = 1,
  parameter bit          RUSER_EN  = 1'b0,
  parameter int unsigned RUSER_W   = 1
) ();
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport rd_mst (
    output araddr, arprot, aruser, arvalid,
    input  arready,
    input  rdata, rresp, ruser, rvalid,
    output rready
  );

  modport rd_slv (
    input  araddr, arprot, aruser, arvalid,
    output arready,
    output rdata, rresp, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/taxi_axil_register_rd.sv
// taxi_axil_register_rd: AXI4-lite read-path register slice.
// AR and R are each registered independently as a bypass, simple buffer or skid buffer.

module taxi_axil_register_rd_slice #(
  parameter int unsigned W        = 1,
  parameter int unsigned REG_TYPE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  if (REG_TYPE == 2) begin : g_skid
    logic [W-1:0] out_data_reg;
    logic [W-1:0] temp_data_reg;
    logic         out_valid_reg, out_valid_next;
    logic         temp_valid_reg, temp_valid_next;
    logic         in_ready_reg, in_ready_next;
    logic         store_in_to_out, store_in_to_temp, store_temp_to_out;

    // in_ready_reg implies temp is empty, so temp only fills while in_ready_reg is low next cycle
    always_comb begin
      out_valid_next    = out_valid_reg;
      temp_valid_next   = temp_valid_reg;
      store_in_to_out   = 1'b0;
      store_in_to_temp  = 1'b0;
      store_temp_to_out = 1'b0;
      in_ready_next     = out_ready || (!temp_valid_reg && (!out_valid_reg || !in_valid));
      if (in_ready_reg) begin
        if (out_ready || !out_valid_reg) begin
          out_valid_next  = in_valid;
          store_in_to_out = 1'b1;
        end else begin
          temp_valid_next  = in_valid;
          store_in_to_temp = 1'b1;
        end
      end else if (out_ready) begin
        out_valid_next    = temp_valid_reg;
        temp_valid_next   = 1'b0;
        store_temp_to_out = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_reg  <= 1'b0;
        temp_valid_reg <= 1'b0;
        in_ready_reg   <= 1'b0;
      end else begin
        out_valid_reg  <= out_valid_next;
        temp_valid_reg <= temp_valid_next;
        in_ready_reg   <= in_ready_next;
      end
    end

    always_ff @(posedge clk) begin
      if (store_in_to_out) begin
        out_data_reg <= in_data;
      end else if (store_temp_to_out) begin
        out_data_reg <= temp_data_reg;
      end
      if (store_in_to_temp) begin
        temp_data_reg <= in_data;
      end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
  end else if (REG_TYPE == 1) begin : g_simple
    logic [W-1:0] out_data_reg;
    logic         out_valid_reg, out_valid_next;
    logic         in_ready_reg;
    logic         store_in;

    always_comb begin
      out_valid_next = out_valid_reg;
      store_in       = 1'b0;
      if (in_ready_reg) begin
        out_valid_next = in_valid;
        store_in       = in_valid;
      end else if (out_ready) begin
        out_valid_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_reg <= 1'b0;
        in_ready_reg  <= 1'b0;
      end else begin
        out_valid_reg <= out_valid_next;
        in_ready_reg  <= !out_valid_next;
      end
    end

    always_ff @(posedge clk) begin
      if (store_in) begin
        out_data_reg <= in_data;
      end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign out_valid = in_valid;
  end
endmodule

module taxi_axil_register_rd #(
  parameter int unsigned AR_REG_TYPE = 2,
  parameter int unsigned R_REG_TYPE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_axil_if.rd_slv s_axil_rd,
  taxi_axil_if.rd_mst m_axil_rd
);
  localparam int unsigned DATA_W    = s_axil_rd.DATA_W;
  localparam int unsigned ADDR_W    = s_axil_rd.ADDR_W;
  localparam int unsigned STRB_W    = s_axil_rd.STRB_W;
  localparam bit          ARUSER_EN = s_axil_rd.ARUSER_EN && m_axil_rd.ARUSER_EN;
  localparam int unsigned ARUSER_W  = s_axil_rd.ARUSER_W;
  localparam bit          RUSER_EN  = s_axil_rd.RUSER_EN && m_axil_rd.RUSER_EN;
  localparam int unsigned RUSER_W   = s_axil_rd.RUSER_W;
  localparam int unsigned AR_W      = ADDR_W + 3 + ARUSER_W;
  localparam int unsigned R_W       = DATA_W + 2 + RUSER_W;

  if (m_axil_rd.DATA_W != DATA_W) begin : g_chk_data
    $fatal(0, "taxi_axil_register_rd: DATA_W mismatch between interfaces");
  end
  if (m_axil_rd.ADDR_W != ADDR_W) begin : g_chk_addr
    $fatal(0, "taxi_axil_register_rd: ADDR_W mismatch between interfaces");
  end
  if (m_axil_rd.STRB_W != STRB_W) begin : g_chk_strb
    $fatal(0, "taxi_axil_register_rd: STRB_W mismatch between interfaces");
  end
  if (AR_REG_TYPE > 2) begin : g_chk_ar_type
    $fatal(0, "taxi_axil_register_rd: AR_REG_TYPE must be 0, 1 or 2");
  end
  if (R_REG_TYPE > 2) begin : g_chk_r_type
    $fatal(0, "taxi_axil_register_rd: R_REG_TYPE must be 0, 1 or 2");
  end

  logic [AR_W-1:0]     ar_in, ar_out;
  logic [ARUSER_W-1:0] ar_user_in;
  logic [R_W-1:0]      r_in, r_out;
  logic [RUSER_W-1:0]  r_user_in;

  assign ar_user_in = ARUSER_EN ? s_axil_rd.aruser : '0;
  assign ar_in      = {s_axil_rd.araddr, s_axil_rd.arprot, ar_user_in};

  taxi_axil_register_rd_slice #(
    .W        (AR_W),
    .REG_TYPE (AR_REG_TYPE)
  ) ar_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (ar_in),
    .in_valid  (s_axil_rd.arvalid),
    .in_ready  (s_axil_rd.arready),
    .out_data  (ar_out),
    .out_valid (m_axil_rd.arvalid),
    .out_ready (m_axil_rd.arready)
  );

  assign m_axil_rd.araddr = ar_out[AR_W-1 -: ADDR_W];
  assign m_axil_rd.arprot = ar_out[ARUSER_W +: 3];
  assign m_axil_rd.aruser = ARUSER_EN ? ar_out[ARUSER_W-1:0] : '0;

  assign r_user_in = RUSER_EN ? m_axil_rd.ruser : '0;
  assign r_in      = {m_axil_rd.rdata, m_axil_rd.rresp, r_user_in};

  taxi_axil_register_rd_slice #(
    .W        (R_W),
    .REG_TYPE (R_REG_TYPE)
  ) r_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (r_in),
    .in_valid  (m_axil_rd.rvalid),
    .in_ready  (m_axil_rd.rready),
    .out_data  (r_out),
    .out_valid (s_axil_rd.rvalid),
    .out_ready (s_axil_rd.rready)
  );

  assign s_axil_rd.rdata = r_out[R_W-1 -: DATA_W];
  assign s_axil_rd.rresp = r_out[RUSER_W +: 2];
  assign s_axil_rd.ruser = RUSER_EN ? r_out[RUSER_W-1:0] : '0;
endmodule

// File: tb/tb_taxi_axil_register_rd.sv
// Bench for taxi_axil_register_rd: nine instances cover every AR/R register type pair.
// Instance index = AR_REG_TYPE*3 + R_REG_TYPE.
module tb_taxi_axil_register_rd;
  localparam int NB = 60;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]       s_arvalid, s_arready, s_rvalid, s_rready;
  logic [8:0]       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [8:0][31:0] s_araddr, m_araddr, s_rdata, m_rdata;
  logic [8:0][2:0]  s_arprot, m_arprot;
  logic [8:0][3:0]  s_aruser, m_aruser, s_ruser, m_ruser;
  logic [8:0][1:0]  s_rresp, m_rresp;

  for (genvar g = 0; g < 9; g++) begin : g_dut
    taxi_axil_if #(.DATA_W(32), .ADDR_W(32), .STRB_W(4), .ARUSER_EN(1'b1), .ARUSER_W(4),
                   .RUSER_EN(1'b1), .RUSER_W(4)) s_if ();
    taxi_axil_if #(.DATA_W(32), .ADDR_W(32), .STRB_W(4), .ARUSER_EN(1'b1), .ARUSER_W(4),
                   .RUSER_EN(1'b1), .RUSER_W(4)) m_if ();

    assign s_if.araddr  = s_araddr[g];
    assign s_if.arprot  = s_arprot[g];
    assign s_if.aruser  = s_aruser[g];
    assign s_if.arvalid = s_arvalid[g];
    assign s_if.rready  = s_rready[g];
    assign s_arready[g] = s_if.arready;
    assign s_rvalid[g]  = s_if.rvalid;
    assign s_rdata[g]   = s_if.rdata;
    assign s_rresp[g]   = s_if.rresp;
    assign s_ruser[g]   = s_if.ruser;

    assign m_arvalid[g] = m_if.arvalid;
    assign m_araddr[g]  = m_if.araddr;
    assign m_arprot[g]  = m_if.arprot;
    assign m_aruser[g]  = m_if.aruser;
    assign m_rready[g]  = m_if.rready;
    assign m_if.arready = m_arready[g];
    assign m_if.rvalid  = m_rvalid[g];
    assign m_if.rdata   = m_rdata[g];
    assign m_if.rresp   = m_rresp[g];
    assign m_if.ruser   = m_ruser[g];

    taxi_axil_register_rd #(
      .AR_REG_TYPE (g / 3),
      .R_REG_TYPE  (g % 3)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_axil_rd (s_if),
      .m_axil_rd (m_if)
    );
  end

  function automatic logic [38:0] ar_beat(input int i, input int k);
    logic [31:0] a;
    a = (32'(k) * 32'h9E37_79B1) ^ (32'(i) << 24);
    return {a, 3'(k + i), 4'(k * 3 + i)};
  endfunction

  function automatic logic [37:0] r_beat(input int i, input int k);
    logic [31:0] d;
    d = (32'(k) * 32'h85EB_CA6B) + 32'(i) * 32'h0101_0101;
    return {d, 2'(k ^ i), 4'(k + 2 * i)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    n_cmp++; if (s_arready[8] !== 1'b0) begin n_err++; $display("FAIL reset_arready: got %b want 0", s_arready[8]); end
    n_cmp++; if (s_rvalid[8] !== 1'b0) begin n_err++; $display("FAIL reset_s_rvalid: got %b want 0", s_rvalid[8]); end
    n_cmp++; if (m_arvalid[8] !== 1'b0) begin n_err++; $display("FAIL reset_m_arvalid: got %b want 0", m_arvalid[8]); end
    n_cmp++; if (m_rready[8] !== 1'b0) begin n_err++; $display("FAIL reset_m_rready: got %b want 0", m_rready[8]); end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    n_cmp++; if (s_arready[8] !== 1'b0) begin n_err++; $display("FAIL release_arready_pre_edge: got %b want 0", s_arready[8]); end
    @(negedge clk);
    #4;
    n_cmp++; if (s_arready[8] !== 1'b1) begin n_err++; $display("FAIL release_arready: got %b want 1", s_arready[8]); end
    n_cmp++; if (m_rready[8] !== 1'b1) begin n_err++; $display("FAIL release_m_rready: got %b want 1", m_rready[8]); end
  endtask

  task automatic test_ar_throughput;
    int sent, rcv, cyc, first;
    sent = 0; rcv = 0; cyc = 0; first = -1;
    m_arready[8] = 1'b1;
    while (rcv < 8 && cyc < 40) begin
      @(negedge clk);
      if (sent < 8) begin
        s_arvalid[8] = 1'b1;
        s_araddr[8]  = 32'(sent * 4);
        s_arprot[8]  = '0;
        s_aruser[8]  = '0;
      end else begin
        s_arvalid[8] = 1'b0;
      end
      #4;
      if (m_arvalid[8]) begin
        n_cmp++; if (m_araddr[8] !== 32'(rcv * 4)) begin n_err++; $display("FAIL thru_addr[%0d]: got %h want %h", rcv, m_araddr[8], 32'(rcv * 4)); end
        n_cmp++; if (cyc !== first + 1 + rcv) begin n_err++; $display("FAIL thru_cycle[%0d]: got %0d want %0d", rcv, cyc, first + 1 + rcv); end
        rcv++;
      end
      if (s_arvalid[8] && s_arready[8]) begin
        if (first < 0) first = cyc;
        sent++;
      end
      cyc++;
    end
    n_cmp++; if (rcv !== 8) begin n_err++; $display("FAIL thru_count: got %0d want 8", rcv); end
    @(negedge clk);
    s_arvalid[8] = 1'b0;
    m_arready[8] = 1'b0;
  endtask

  task automatic test_skid_stall;
    m_arready[8] = 1'b0;
    @(negedge clk);
    s_arvalid[8] = 1'b1; s_araddr[8] = 32'h10;
    #4;
    n_cmp++; if (s_arready[8] !== 1'b1) begin n_err++; $display("FAIL skid_acc0: got %b want 1", s_arready[8]); end
    @(negedge clk);
    s_araddr[8] = 32'h14;
    #4;
    n_cmp++; if (s_arready[8] !== 1'b1) begin n_err++; $display("FAIL skid_acc1: got %b want 1", s_arready[8]); end
    n_cmp++; if (m_arvalid[8] !== 1'b1) begin n_err++; $display("FAIL skid_first_valid: got %b want 1", m_arvalid[8]); end
    n_cmp++; if (m_araddr[8] !== 32'h10) begin n_err++; $display("FAIL skid_first_addr: got %h want 10", m_araddr[8]); end
    @(negedge clk);
    s_arvalid[8] = 1'b0;
    #4;
    n_cmp++; if (s_arready[8] !== 1'b0) begin n_err++; $display("FAIL skid_full_ready: got %b want 0", s_arready[8]); end
    n_cmp++; if (m_araddr[8] !== 32'h10) begin n_err++; $display("FAIL skid_hold_addr: got %h want 10", m_araddr[8]); end
    @(negedge clk);
    m_arready[8] = 1'b1;
    #4;
    n_cmp++; if (m_arvalid[8] !== 1'b1 || m_araddr[8] !== 32'h10) begin n_err++; $display("FAIL skid_out0: got v=%b a=%h want v=1 a=10", m_arvalid[8], m_araddr[8]); end
    @(negedge clk);
    #4;
    n_cmp++; if (m_arvalid[8] !== 1'b1 || m_araddr[8] !== 32'h14) begin n_err++; $display("FAIL skid_out1: got v=%b a=%h want v=1 a=14", m_arvalid[8], m_araddr[8]); end
    @(negedge clk);
    #4;
    n_cmp++; if (m_arvalid[8] !== 1'b0) begin n_err++; $display("FAIL skid_drained: got %b want 0", m_arvalid[8]); end
    m_arready[8] = 1'b0;
  endtask

  task automatic test_r_simple;
    logic [4:0]  exp_v;
    logic [31:0] d0, d1, exp_d;
    int k, rx;
    exp_v = 5'b01010;
    d0 = 32'hDEAD_BEEF; d1 = 32'h1234_5678;
    k = 0; rx = 0;
    s_rready[7] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (k < 2) begin
        m_rvalid[7] = 1'b1;
        m_rdata[7]  = (k == 0) ? d0 : d1;
        m_rresp[7]  = 2'b00;
        m_ruser[7]  = '0;
      end else begin
        m_rvalid[7] = 1'b0;
      end
      #4;
      n_cmp++; if (s_rvalid[7] !== exp_v[c]) begin n_err++; $display("FAIL r_simple_valid[%0d]: got %b want %b", c, s_rvalid[7], exp_v[c]); end
      if (s_rvalid[7]) begin
        exp_d = (rx == 0) ? d0 : d1;
        n_cmp++; if (s_rdata[7] !== exp_d) begin n_err++; $display("FAIL r_simple_data[%0d]: got %h want %h", rx, s_rdata[7], exp_d); end
        n_cmp++; if (s_rresp[7] !== 2'b00) begin n_err++; $display("FAIL r_simple_resp[%0d]: got %b want 00", rx, s_rresp[7]); end
        rx++;
      end
      if (m_rvalid[7] && m_rready[7]) k++;
    end
    n_cmp++; if (rx !== 2) begin n_err++; $display("FAIL r_simple_count: got %0d want 2", rx); end
    m_rvalid[7] = 1'b0;
    s_rready[7] = 1'b0;
  endtask

  task automatic test_bypass;
    @(negedge clk);
    s_arvalid[0] = 1'b1; s_araddr[0] = 32'hA5A5_A5A4; m_arready[0] = 1'b0;
    m_rvalid[0] = 1'b1; m_rdata[0] = 32'hCAFE_F00D; m_rresp[0] = 2'b10; s_rready[0] = 1'b0;
    #1;
    n_cmp++; if (m_arvalid[0] !== 1'b1) begin n_err++; $display("FAIL byp_arvalid: got %b want 1", m_arvalid[0]); end
    n_cmp++; if (m_araddr[0] !== 32'hA5A5_A5A4) begin n_err++; $display("FAIL byp_araddr: got %h want a5a5a5a4", m_araddr[0]); end
    n_cmp++; if (s_arready[0] !== 1'b0) begin n_err++; $display("FAIL byp_arready_lo: got %b want 0", s_arready[0]); end
    n_cmp++; if (s_rvalid[0] !== 1'b1) begin n_err++; $display("FAIL byp_rvalid: got %b want 1", s_rvalid[0]); end
    n_cmp++; if (s_rdata[0] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL byp_rdata: got %h want cafef00d", s_rdata[0]); end
    n_cmp++; if (s_rresp[0] !== 2'b10) begin n_err++; $display("FAIL byp_rresp: got %b want 10", s_rresp[0]); end
    n_cmp++; if (m_rready[0] !== 1'b0) begin n_err++; $display("FAIL byp_rready_lo: got %b want 0", m_rready[0]); end
    m_arready[0] = 1'b1; s_rready[0] = 1'b1;
    #1;
    n_cmp++; if (s_arready[0] !== 1'b1) begin n_err++; $display("FAIL byp_arready_hi: got %b want 1", s_arready[0]); end
    n_cmp++; if (m_rready[0] !== 1'b1) begin n_err++; $display("FAIL byp_rready_hi: got %b want 1", m_rready[0]); end
    s_arvalid[0] = 1'b0; m_rvalid[0] = 1'b0; m_arready[0] = 1'b0; s_rready[0] = 1'b0;
  endtask

  int  ar_sent [9], ar_rcv [9], r_sent [9], r_rcv [9];
  bit  ar_acc [9], r_acc [9];

  task automatic test_random;
    int  cyc;
    bit  done;
    cyc = 0; done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ar_sent[i] = 0; ar_rcv[i] = 0; r_sent[i] = 0; r_rcv[i] = 0;
      ar_acc[i] = 1'b0; r_acc[i] = 1'b0;
    end
    while (!done && cyc < 3000) begin
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        if (ar_acc[i]) begin s_arvalid[i] = 1'b0; ar_acc[i] = 1'b0; end
        if (!s_arvalid[i] && ar_sent[i] < NB && $urandom_range(0, 3) != 0) begin
          {s_araddr[i], s_arprot[i], s_aruser[i]} = ar_beat(i, ar_sent[i]);
          s_arvalid[i] = 1'b1;
        end
        if (r_acc[i]) begin m_rvalid[i] = 1'b0; r_acc[i] = 1'b0; end
        if (!m_rvalid[i] && r_sent[i] < NB && $urandom_range(0, 3) != 0) begin
          {m_rdata[i], m_rresp[i], m_ruser[i]} = r_beat(i, r_sent[i]);
          m_rvalid[i] = 1'b1;
        end
        m_arready[i] = 1'($urandom_range(0, 1));
        s_rready[i]  = 1'($urandom_range(0, 1));
      end
      #4;
      done = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (m_arvalid[i] && m_arready[i]) begin
          n_cmp++;
          if ({m_araddr[i], m_arprot[i], m_aruser[i]} !== ar_beat(i, ar_rcv[i])) begin
            n_err++;
            $display("FAIL rand_ar inst %0d beat %0d: got %h want %h", i, ar_rcv[i],
                     {m_araddr[i], m_arprot[i], m_aruser[i]}, ar_beat(i, ar_rcv[i]));
          end
          ar_rcv[i]++;
        end
        if (s_arvalid[i] && s_arready[i]) begin ar_sent[i]++; ar_acc[i] = 1'b1; end
        if (s_rvalid[i] && s_rready[i]) begin
          n_cmp++;
          if ({s_rdata[i], s_rresp[i], s_ruser[i]} !== r_beat(i, r_rcv[i])) begin
            n_err++;
            $display("FAIL rand_r inst %0d beat %0d: got %h want %h", i, r_rcv[i],
                     {s_rdata[i], s_rresp[i], s_ruser[i]}, r_beat(i, r_rcv[i]));
          end
          r_rcv[i]++;
        end
        if (m_rvalid[i] && m_rready[i]) begin r_sent[i]++; r_acc[i] = 1'b1; end
        if (ar_rcv[i] < NB || r_rcv[i] < NB) done = 1'b0;
      end
      cyc++;
    end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (ar_rcv[i] !== NB) begin n_err++; $display("FAIL rand_ar_count inst %0d: got %0d want %0d", i, ar_rcv[i], NB); end
      n_cmp++; if (r_rcv[i] !== NB) begin n_err++; $display("FAIL rand_r_count inst %0d: got %0d want %0d", i, r_rcv[i], NB); end
    end
    @(negedge clk);
    s_arvalid = '0; m_rvalid = '0; m_arready = '0; s_rready = '0;
  endtask

  initial begin
    rst_n     = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_aruser = '0; s_rready = '0;
    m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0; m_ruser = '0;
    test_reset;
    test_ar_throughput;
    test_skid_stall;
    test_r_simple;
    test_bypass;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
